// File: rtl/plcp_descrambler.sv
// PLCP DATA-field descrambler for x^7+x^4+1: seeds from SERVICE bits 0..6,
// checks SERVICE bits 7..15 are zero, then emits exactly 8*Length PSDU bits.
module plcp_descrambler #(
    parameter int LEN_WIDTH = 12
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [LEN_WIDTH-1:0] Length,
    input  logic                 InValid,
    input  logic                 Input,
    output logic                 Output,
    output logic                 OutValid,
    output logic                 Done,
    output logic                 ServiceError,
    output logic                 Busy,
    output logic [2:0]           DebugState
);

    // Input is consumed on a rising edge only when InValid=1 (no backpressure);
    // OutValid/Done are single-cycle strobes registered on that same edge.
    localparam int CW = LEN_WIDTH + 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEED    = 3'd1,
        S_SERVICE = 3'd2,
        S_DATA    = 3'd3,
        S_FLUSH   = 3'd4
    } state_e;

    state_e               state_q;
    logic [6:0]           scr_q;      // scr_q[6] is s7, scr_q[0] is s1
    logic [CW-1:0]        cnt_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 out_q;
    logic                 out_valid_q;
    logic                 done_q;
    logic                 svc_err_q;

    logic                 key;
    logic                 plain;
    logic [CW-1:0]        cnt_inc;
    logic [CW-1:0]        data_bits;

    assign key       = scr_q[6] ^ scr_q[3];
    assign plain     = Input ^ key;
    assign cnt_inc   = cnt_q + 1'b1;
    assign data_bits = {len_q, 3'b000};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            scr_q       <= 7'h7F;
            cnt_q       <= '0;
            len_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            svc_err_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (Start) begin
                // A Start-cycle bit is SERVICE bit 0 of the new frame
                state_q   <= S_SEED;
                len_q     <= Length;
                svc_err_q <= 1'b0;
                if (InValid) begin
                    scr_q <= {scr_q[5:0], Input};
                    cnt_q <= CW'(1);
                end else begin
                    cnt_q <= '0;
                end
            end else if (InValid) begin
                case (state_q)
                    S_SEED: begin
                        scr_q <= {scr_q[5:0], Input};
                        if (cnt_q == CW'(6)) begin
                            cnt_q   <= '0;
                            state_q <= S_SERVICE;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_SERVICE: begin
                        scr_q <= {scr_q[5:0], key};
                        if (plain) svc_err_q <= 1'b1;
                        if (cnt_q == CW'(8)) begin
                            cnt_q <= '0;
                            if (len_q == '0) begin
                                state_q <= S_FLUSH;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    S_DATA: begin
                        scr_q       <= {scr_q[5:0], key};
                        out_q       <= plain;
                        out_valid_q <= 1'b1;
                        if (cnt_inc == data_bits) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_FLUSH;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Output       = out_q;
    assign OutValid     = out_valid_q;
    assign Done         = done_q;
    assign ServiceError = svc_err_q;
    assign Busy         = (state_q == S_SEED) || (state_q == S_SERVICE) || (state_q == S_DATA);
    assign DebugState   = state_q;

endmodule

// File: tb/tb_plcp_descrambler.sv
// Bench for plcp_descrambler: frames built by a transmitter-side scrambler model
// (keystream recurrence over an array), checked bit-by-bit through an expected queue.
module tb_plcp_descrambler;

    localparam int LW = 12;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic [LW-1:0] Length;
    logic          InValid;
    logic          Input;
    logic          Output;
    logic          OutValid;
    logic          Done;
    logic          ServiceError;
    logic          Busy;
    logic [2:0]    DebugState;

    plcp_descrambler #(.LEN_WIDTH(LW)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Length(Length),
        .InValid(InValid), .Input(Input), .Output(Output), .OutValid(OutValid),
        .Done(Done), .ServiceError(ServiceError), .Busy(Busy), .DebugState(DebugState)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];
    logic last_out = 1'b0;
    int out_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int svc_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: samples 1 time unit after each rising edge
    always begin
        logic [0:0] e;
        @(posedge Clock);
        #1;
        if (!Reset) begin
            if (!InValid) begin
                check("gap_outvalid", OutValid, 0);
                check("gap_done", Done, 0);
            end
            if (OutValid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_out", OutValid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bit", Output, e);
                    last_out = e;
                end
            end else begin
                check("out_hold", Output, last_out);
            end
            if (Done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_last", exp_q.size(), 0);
            end
        end
    end

    // Driver: builds one frame (SERVICE zeros + PSDU + tail/pad), scrambles it with
    // the transmitter keystream and sends it. stop_after>=0 stops after that many PSDU bits.
    task automatic send_frame(input logic [6:0] seed, input int len, input int flip,
                              input int gap_pct, input int stop_after, input bit use_lit);
        logic x   [0:199];
        logic d   [0:191];
        logic scr [0:191];
        logic [23:0] lit;
        logic [7:0]  b;
        int npad;
        int nbits;
        int last;
        lit   = 24'b000011101111001011001001;
        npad  = 6 + $urandom_range(0, 8);
        nbits = 16 + 8 * len + npad;
        for (int i = 0; i < 7; i++) x[i] = seed[6-i];
        for (int n = 0; n < nbits; n++) x[n+7] = x[n] ^ x[n+3];
        for (int n = 0; n < nbits; n++) d[n] = 1'b0;
        for (int j = 0; j < len; j++) begin
            b = use_lit ? 8'h00 : 8'($urandom);
            for (int t = 0; t < 8; t++) d[16 + 8*j + t] = b[t];
        end
        for (int n = 0; n < nbits; n++) scr[n] = d[n] ^ x[n+7];
        if (use_lit) for (int n = 0; n < 24; n++) scr[n] = lit[23-n];
        if (flip >= 0) scr[flip] = ~scr[flip];
        last = (stop_after >= 0) ? 16 + stop_after : nbits;

        @(negedge Clock);
        exp_q.delete();
        out_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
        svc_cyc  = -1;
        for (int j = 0; j < 8 * len; j++) exp_q.push_back(d[16+j]);
        Start   = 1'b1;
        Length  = LW'(len);
        InValid = 1'b1;
        Input   = scr[0];
        for (int n = 1; n < last; n++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (n == 1) begin
                check("busy_seed", Busy, 1);
                check("err_cleared", ServiceError, 0);
            end
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 99) < gap_pct) begin
                    InValid = 1'b0;
                    Input   = 1'($urandom);
                    @(negedge Clock);
                end
            end
            InValid = 1'b1;
            Input   = scr[n];
            if (n == 15) svc_cyc = cyc + 1;
        end
        if (stop_after < 0) begin
            @(negedge Clock);
            InValid = 1'b0;
            Input   = 1'b0;
        end
    endtask

    task automatic finish_frame(input int exp_out, input int exp_done, input logic exp_err);
        repeat (2) @(negedge Clock);
        check("out_count", out_cnt, exp_out);
        check("done_count", done_cnt, exp_done);
        check("service_err", ServiceError, exp_err);
        check("busy_after", Busy, 0);
        check("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        int len;
        int flip;
        logic err;
        Reset   = 1'b1;
        Start   = 1'b0;
        Length  = '0;
        InValid = 1'b0;
        Input   = 1'b0;
        #2;
        check("rst_output", Output, 0);
        check("rst_outvalid", OutValid, 0);
        check("rst_done", Done, 0);
        check("rst_svcerr", ServiceError, 0);
        check("rst_busy", Busy, 0);
        check("rst_state", DebugState, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // bits in IDLE are ignored
        repeat (6) begin
            @(negedge Clock);
            InValid = 1'b1;
            Input   = 1'($urandom);
        end
        @(negedge Clock);
        InValid = 1'b0;
        repeat (2) @(negedge Clock);
        check("idle_out_count", out_cnt, 0);
        check("idle_busy", Busy, 0);

        // one-octet reference frame
        send_frame(7'h7F, 1, -1, 0, -1, 1);
        finish_frame(8, 1, 0);

        // corrupted SERVICE bit 10: error sticks, PSDU still decodes
        send_frame(7'h7F, 1, 10, 0, -1, 1);
        finish_frame(8, 1, 1);
        repeat (4) @(negedge Clock);
        check("err_held", ServiceError, 1);

        // empty frame
        send_frame(7'h7F, 0, -1, 0, -1, 0);
        finish_frame(0, 1, 0);
        check("len0_done_cycle", done_cyc, svc_cyc);
        check("len0_flush", DebugState, 4);

        // InValid gaps
        send_frame(7'h7F, 1, -1, 40, -1, 1);
        finish_frame(8, 1, 0);

        // abort after 5 PSDU bits, then a full frame
        send_frame(7'h7F, 1, -1, 0, 5, 1);
        @(posedge Clock);
        #2;
        check("abort_out_count", out_cnt, 5);
        check("abort_no_done", done_cnt, 0);
        send_frame(7'h7F, 1, -1, 0, -1, 1);
        finish_frame(8, 1, 0);

        // asynchronous reset in DATA
        send_frame(7'($urandom), 3, -1, 0, 4, 0);
        @(negedge Clock);
        check("pre_rst_outvalid", OutValid, 1);
        #3;
        Reset   = 1'b1;
        InValid = 1'b0;
        exp_q.delete();
        last_out = 1'b0;
        #1;
        check("arst_output", Output, 0);
        check("arst_outvalid", OutValid, 0);
        check("arst_done", Done, 0);
        check("arst_svcerr", ServiceError, 0);
        check("arst_busy", Busy, 0);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_out_count", out_cnt, 4);
        check("rst_no_done", done_cnt, 0);
        check("rst_idle", DebugState, 0);
        send_frame(7'($urandom), 2, -1, 20, -1, 0);
        finish_frame(16, 1, 0);

        // randomized frames
        for (int r = 0; r < 10; r++) begin
            len  = $urandom_range(0, 4);
            flip = ($urandom_range(0, 2) == 0) ? $urandom_range(7, 15) : -1;
            err  = (flip >= 0);
            send_frame(7'($urandom), len, flip, 30, -1, 0);
            finish_frame(8 * len, 1, err);
            if (len == 0) check("rnd_len0_done_cycle", done_cyc, svc_cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
